// File: rtl/bp_pkg.sv
// Shared types for the branch update controller: payload widths and the
// in-flight entry record kept per unresolved branch.
package bp_pkg;

    localparam int PC_W   = 10;
    localparam int HIST_W = 3;

    // One unresolved branch: its PC, the speculative history it was
    // predicted with, and the direction that was predicted.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [HIST_W-1:0] hist;
        logic              pred;
    } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of unresolved branches. Pointers wrap modulo DEPTH, so
// DEPTH does not need to be a power of two. clear empties the queue in one
// cycle and wins over any same-cycle push or pop.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  bp_entry_t push_data,
    input  logic      pop,
    input  logic      clear,
    output logic      full,
    output logic      empty,
    output bp_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    bp_entry_t        mem [DEPTH];

    logic push_ok;
    logic pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status flags, head view and guarded push/pop qualifiers.
    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        head    = mem[rd_ptr];
        push_ok = push && !full && !clear;
        pop_ok  = pop && !empty && !clear;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/branch_update_ctrl.sv
// Branch predictor update controller: tracks speculative and committed
// global history, queues predicted branches until they resolve, and issues
// a one-cycle-latency table training strobe per resolved branch. A wrong
// prediction or an external flush discards everything still in flight and
// rewinds the speculative history to the committed one.
// PC_W and HIST_W must match the widths fixed in bp_pkg.
module branch_update_ctrl #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 10,
    parameter int HIST_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_valid,
    input  logic [PC_W-1:0]   fetch_pc,
    input  logic              fetch_pred,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic              flush,
    output logic              stall,
    output logic [HIST_W-1:0] spec_hist,
    output logic              tbl_we,
    output logic [PC_W-1:0]   tbl_pc,
    output logic [HIST_W-1:0] tbl_hist,
    output logic              tbl_taken,
    output logic              mispredict
);

    import bp_pkg::*;

    logic              full;
    logic              empty;
    bp_entry_t         head;
    bp_entry_t         push_data;
    logic              push;
    logic              pop;
    logic              clear;
    logic              mispred_now;
    logic [HIST_W-1:0] arch_hist;
    logic [HIST_W-1:0] arch_next;
    logic [HIST_W-1:0] spec_next;

    bp_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (clear),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    // Resolve first, then decide whether the fetch may enter the queue;
    // a mispredict or flush squashes the fetch and rewinds history to the
    // committed value including this cycle's resolved bit.
    always_comb begin
        stall       = full;
        pop         = resolve_valid && !empty;
        mispred_now = pop && (resolve_taken != head.pred);
        push        = fetch_valid && !full && !mispred_now && !flush;
        clear       = mispred_now || flush;
        push_data   = '{pc: fetch_pc, hist: spec_hist, pred: fetch_pred};

        arch_next = arch_hist;
        if (pop) arch_next = {arch_hist[HIST_W-2:0], resolve_taken};

        spec_next = spec_hist;
        if (clear)     spec_next = arch_next;
        else if (push) spec_next = {spec_hist[HIST_W-2:0], fetch_pred};
    end

    // History registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_hist <= '0;
            arch_hist <= '0;
        end else begin
            spec_hist <= spec_next;
            arch_hist <= arch_next;
        end
    end

    // Training strobe and payload, registered one cycle after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_we     <= 1'b0;
            mispredict <= 1'b0;
            tbl_pc     <= '0;
            tbl_hist   <= '0;
            tbl_taken  <= 1'b0;
        end else begin
            tbl_we     <= pop;
            mispredict <= mispred_now;
            if (pop) begin
                tbl_pc    <= head.pc;
                tbl_hist  <= head.hist;
                tbl_taken <= resolve_taken;
            end
        end
    end

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Directed, table-driven bench for branch_update_ctrl. Each vector is
// applied for one clock; registered outputs, history and occupancy are
// compared 1 ns after the edge.
module tb_branch_update_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_valid;
    logic [9:0] fetch_pc;
    logic       fetch_pred;
    logic       resolve_valid;
    logic       resolve_taken;
    logic       flush;
    logic       stall;
    logic [2:0] spec_hist;
    logic       tbl_we;
    logic [9:0] tbl_pc;
    logic [2:0] tbl_hist;
    logic       tbl_taken;
    logic       mispredict;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_update_ctrl #(.DEPTH(4), .PC_W(10), .HIST_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_pred    (fetch_pred),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .flush         (flush),
        .stall         (stall),
        .spec_hist     (spec_hist),
        .tbl_we        (tbl_we),
        .tbl_pc        (tbl_pc),
        .tbl_hist      (tbl_hist),
        .tbl_taken     (tbl_taken),
        .mispredict    (mispredict)
    );

    typedef struct {
        logic       fv;
        logic [9:0] pc;
        logic       pred;
        logic       rv;
        logic       taken;
        logic       fl;
        logic       e_we;
        logic [9:0] e_pc;
        logic [2:0] e_hist;
        logic       e_taken;
        logic       e_mis;
        logic [2:0] e_spec;
        logic [2:0] e_arch;
        int         e_cnt;
        logic       e_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic fv, input logic [9:0] pc, input logic pred,
        input logic rv, input logic taken, input logic fl,
        input logic e_we, input logic [9:0] e_pc, input logic [2:0] e_hist,
        input logic e_taken, input logic e_mis,
        input logic [2:0] e_spec, input logic [2:0] e_arch,
        input int e_cnt, input logic e_stall);
        vec_t v;
        v.fv = fv; v.pc = pc; v.pred = pred; v.rv = rv; v.taken = taken; v.fl = fl;
        v.e_we = e_we; v.e_pc = e_pc; v.e_hist = e_hist; v.e_taken = e_taken;
        v.e_mis = e_mis; v.e_spec = e_spec; v.e_arch = e_arch;
        v.e_cnt = e_cnt; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fv, input logic [9:0] pc, input logic pred,
                         input logic rv, input logic taken, input logic fl);
        fetch_valid   = fv;
        fetch_pc      = pc;
        fetch_pred    = pred;
        resolve_valid = rv;
        resolve_taken = taken;
        flush         = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // fv pc pred rv tk fl | we pc hist tk mis spec arch cnt stall
        // two pushes, two correct resolves, resolve on empty queue
        vecs.push_back(mk(1, 10'h005, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1, 0));
        vecs.push_back(mk(1, 10'h00A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 3'b000, 2, 0));
        vecs.push_back(mk(0, 10'h000, 0, 1, 1, 0, 1, 10'h005, 3'b000, 1, 0, 3'b010, 3'b001, 1, 0));
        vecs.push_back(mk(0, 10'h000, 0, 1, 0, 0, 1, 10'h00A, 3'b001, 0, 0, 3'b010, 3'b010, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, 0, 0));
        // fill to DEPTH, fetch under stall, pop+fetch while full, pop+push with wrap
        vecs.push_back(mk(1, 10'h011, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b101, 3'b010, 1, 0));
        vecs.push_back(mk(1, 10'h022, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b011, 3'b010, 2, 0));
        vecs.push_back(mk(1, 10'h033, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b110, 3'b010, 3, 0));
        vecs.push_back(mk(1, 10'h044, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b101, 3'b010, 4, 1));
        vecs.push_back(mk(1, 10'h055, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b101, 3'b010, 4, 1));
        vecs.push_back(mk(1, 10'h066, 0, 1, 1, 0, 1, 10'h011, 3'b010, 1, 0, 3'b101, 3'b101, 3, 0));
        vecs.push_back(mk(1, 10'h077, 1, 1, 1, 0, 1, 10'h022, 3'b101, 1, 0, 3'b011, 3'b011, 3, 0));
        // mispredict with 3 queued and a same-cycle fetch
        vecs.push_back(mk(0, 10'h000, 0, 1, 0, 0, 1, 10'h033, 3'b011, 0, 0, 3'b011, 3'b110, 2, 0));
        vecs.push_back(mk(1, 10'h088, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b110, 3'b110, 3, 0));
        vecs.push_back(mk(1, 10'h099, 1, 1, 0, 0, 1, 10'h044, 3'b110, 0, 1, 3'b100, 3'b100, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 3'b100, 0, 0));
        // flush with same-cycle resolve and fetch, then flush with fetch only
        vecs.push_back(mk(1, 10'h0AB, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b100, 1, 0));
        vecs.push_back(mk(1, 10'h0CD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b011, 3'b100, 2, 0));
        vecs.push_back(mk(1, 10'h0EE, 0, 1, 1, 1, 1, 10'h0AB, 3'b100, 1, 0, 3'b001, 3'b001, 0, 0));
        vecs.push_back(mk(0, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b001, 0, 0));
        vecs.push_back(mk(1, 10'h0F0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3'b001, 3'b001, 0, 0));

        rst = 1'b1;
        drive(0, 10'h000, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_tbl_we", int'(tbl_we), 0);
        chk("rst_mispredict", int'(mispredict), 0);
        chk("rst_spec_hist", int'(spec_hist), 0);
        chk("rst_stall", int'(stall), 0);
        chk("rst_count", int'(dut.u_fifo.count), 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].pred, vecs[i].rv, vecs[i].taken, vecs[i].fl);
            tick();
            chk($sformatf("v%0d_tbl_we", i), int'(tbl_we), int'(vecs[i].e_we));
            chk($sformatf("v%0d_mispredict", i), int'(mispredict), int'(vecs[i].e_mis));
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_tbl_pc", i), int'(tbl_pc), int'(vecs[i].e_pc));
                chk($sformatf("v%0d_tbl_hist", i), int'(tbl_hist), int'(vecs[i].e_hist));
                chk($sformatf("v%0d_tbl_taken", i), int'(tbl_taken), int'(vecs[i].e_taken));
            end
            chk($sformatf("v%0d_spec_hist", i), int'(spec_hist), int'(vecs[i].e_spec));
            chk($sformatf("v%0d_arch_hist", i), int'(dut.arch_hist), int'(vecs[i].e_arch));
            chk($sformatf("v%0d_count", i), int'(dut.u_fifo.count), vecs[i].e_cnt);
            chk($sformatf("v%0d_stall", i), int'(stall), int'(vecs[i].e_stall));
        end

        // Reset mid-operation with three entries queued and a resolve pending.
        drive(1, 10'h101, 0, 0, 0, 0); tick();
        drive(1, 10'h102, 0, 0, 0, 0); tick();
        drive(1, 10'h103, 0, 0, 0, 0); tick();
        chk("pre_rst_count", int'(dut.u_fifo.count), 3);
        chk("pre_rst_spec_hist", int'(spec_hist), 3'b000);
        rst = 1'b1;
        drive(1, 10'h104, 1, 1, 1, 0);
        tick();
        chk("midrst_tbl_we", int'(tbl_we), 0);
        chk("midrst_mispredict", int'(mispredict), 0);
        chk("midrst_tbl_pc", int'(tbl_pc), 0);
        chk("midrst_tbl_hist", int'(tbl_hist), 0);
        chk("midrst_tbl_taken", int'(tbl_taken), 0);
        chk("midrst_spec_hist", int'(spec_hist), 0);
        chk("midrst_arch_hist", int'(dut.arch_hist), 0);
        chk("midrst_count", int'(dut.u_fifo.count), 0);
        rst = 1'b0;
        drive(0, 10'h000, 0, 1, 1, 0);
        tick();
        chk("empty_resolve_tbl_we", int'(tbl_we), 0);
        chk("empty_resolve_count", int'(dut.u_fifo.count), 0);
        chk("empty_resolve_arch", int'(dut.arch_hist), 0);
        drive(0, 10'h000, 0, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_update_ctrl.md
BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of in-flight unresolved branches.
REQ-002 SHALL have parameter PC_W, default 10, meaning the fetch PC width.
REQ-003 SHALL have parameter HIST_W, default 3, meaning the global history width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 fetch_valid  in  1  a branch was fetched and predicted this cycle.
REQ-007 fetch_pc  in  PC_W  PC of the fetched branch.
REQ-008 fetch_pred  in  1  prediction from the tables (1 = taken).
REQ-009 resolve_valid  in  1  the oldest in-flight branch resolved this cycle.
REQ-010 resolve_taken  in  1  actual outcome of the resolving branch.
REQ-011 flush  in  1  external pipeline flush; discards all in-flight branches.
REQ-012 stall  out  1  queue full; fetch holds branch fetch.
REQ-013 spec_hist  out  HIST_W  speculative global history; drives the table prev_history input.
REQ-014 tbl_we  out  1  table update strobe.
REQ-015 tbl_pc  out  PC_W  PC of the branch being trained.
REQ-016 tbl_hist  out  HIST_W  history at prediction time of the branch being trained.
REQ-017 tbl_taken  out  1  training outcome.
REQ-018 mispredict  out  1  one-cycle pulse on a wrong prediction.

Function
REQ-019 SHALL keep an in-order FIFO of DEPTH entries; each entry holds {pc, spec_hist at push, pred}, plus an occupancy count of 0..DEPTH.
REQ-020 stall SHALL be combinational and equal 1 exactly when count == DEPTH.
REQ-021 A push SHALL occur when fetch_valid=1, stall=0, no mispredict is being detected, and flush=0; spec_hist SHALL then become {spec_hist[HIST_W-2:0], fetch_pred}.
REQ-022 fetch_valid while stall=1 SHALL be ignored, with no push and no history change, even if a pop occurs in the same cycle.
REQ-023 A pop SHALL occur when resolve_valid=1 and count>0; resolve_valid with count==0 SHALL be ignored.
REQ-024 On a pop, in the next cycle tbl_we=1, tbl_pc=head.pc, tbl_hist=head.hist and tbl_taken=resolve_taken, giving a fixed latency of 1; otherwise tbl_we=0.
REQ-025 On a pop, the committed history arch_hist SHALL become {arch_hist[HIST_W-2:0], resolve_taken}.
REQ-026 A pop with resolve_taken != head.pred SHALL be a misprediction; mispredict SHALL be 1 in the next cycle, aligned with tbl_we.
REQ-027 On a misprediction, the remaining FIFO entries SHALL be discarded (count := 0), spec_hist SHALL be set to the new arch_hist value, and any same-cycle push SHALL be dropped.
REQ-028 flush=1 SHALL set count := 0 and spec_hist := arch_hist; a same-cycle pop SHALL be processed first, so that its training and arch_hist update take effect and spec_hist takes the updated arch_hist.
REQ-029 Simultaneous push and pop without misprediction SHALL leave count unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-030 History shifts SHALL drop the MSB; all widths SHALL be exact, with no sign extension.

Reset
REQ-031 When rst=1, count, pointers, spec_hist and arch_hist SHALL be 0, and tbl_we, mispredict, tbl_pc, tbl_hist and tbl_taken SHALL be 0 in the following cycle.
REQ-032 rst SHALL take priority over all other inputs, including mid-operation; in-flight entries are lost and no training strobe is issued for them.
REQ-033 FIFO payload storage SHALL not require reset.

Structure
REQ-034 A shared package bp_pkg SHALL hold PC_W, HIST_W and the entry struct type bp_entry_t {pc, hist, pred}.
REQ-035 The FIFO SHALL be a sub-module named bp_inflight_fifo with push, pop, clear, full, empty and head ports; the history and training logic stay in the top level.

Verification
REQ-036 After reset, push pc 0x005 pred=1, then 0x00A pred=0 -> spec_hist=3'b010, count=2.
REQ-037 With both entries queued, resolve taken=1 then taken=0 -> tbl_we pulses with (0x005, hist 000, taken 1) then (0x00A, hist 001, taken 0), mispredict stays 0, arch_hist=3'b010.
REQ-038 Push 4 entries with DEPTH=4 -> stall=1; a 5th fetch_valid is ignored; a pop plus fetch in the same cycle leaves count=3.
REQ-039 Queue 3 entries with the head pred=1, then resolve taken=0 -> next cycle mispredict=1 and tbl_taken=0; count=0; spec_hist=arch_hist; a same-cycle fetch is dropped.
REQ-040 With count=2, flush together with resolve taken=1 -> tbl_we next cycle, count=0, spec_hist=arch_hist, including the new bit.
REQ-041 rst asserted with count=3 -> no tbl_we, all outputs 0; a resolve_valid on the empty queue afterward gives no tbl_we.
